mapped_mem_ctrl: RTL and testbench

- Parametrised, address-mapped word memory with a valid/ready request channel and an in-order response channel.
- Adds byte write masks, a configurable read latency, backpressure, and error responses for out-of-window or misaligned accesses.
- Used as the behavioural instruction/data memory behind the Sodor core wrappers and their testbenches.

---
 rtl/mapped_mem_ctrl_if.sv | 31 +++
 rtl/mapped_mem_ctrl.sv | 121 ++++++++++++
 tb/tb_mapped_mem_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mapped_mem_ctrl_if.sv
// mapped_mem_ctrl_if
//   Request/response bus for mapped_mem_ctrl.
//   Request side : req_valid/req_ready handshake carrying wen, byte address,
//                  write data and per-byte write mask.
//   Response side: resp_valid/resp_ready handshake carrying read data and an
//                  error flag. Responses come back in request order.
//   master drives requests and consumes responses; slave is the memory.
interface mapped_mem_ctrl_if #(
    parameter int BITS = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [BITS-1:0]   req_addr;
    logic [BITS-1:0]   req_wdata;
    logic [BITS/8-1:0] req_wmask;
    logic              resp_valid;
    logic              resp_ready;
    logic [BITS-1:0]   resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mapped_mem_ctrl.sv
// mapped_mem_ctrl
//   Address-mapped word memory with byte write masks, fixed read latency,
//   response backpressure and error responses for misses.
// Ports:
//   clk     - clock, all state on the rising edge
//   rst_n   - synchronous reset, ACTIVE HIGH despite the name
//   offset  - byte address of word 0, captured while rst_n=1
//   bus     - mapped_mem_ctrl_if.slave request/response channel
module mapped_mem_ctrl #(
    parameter int BITS       = 32,
    parameter int WORD_DEPTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] offset,
    mapped_mem_ctrl_if.slave bus
);
    localparam int              BYTES   = BITS / 8;
    localparam int              IW      = $clog2(WORD_DEPTH);
    localparam int              CW      = $clog2(LATENCY + 1);
    localparam logic [BITS-1:0] BYTES_W = BITS'(BYTES);
    localparam logic [BITS-1:0] DEPTH_W = BITS'(WORD_DEPTH);
    localparam logic [CW-1:0]   LAT_W   = CW'(LATENCY);

    typedef struct packed {
        logic            err;
        logic [BITS-1:0] rdata;
    } resp_t;

    logic [BITS-1:0] mem_q [WORD_DEPTH];
    logic [BITS-1:0] base_q;

    // Fixed-length delay line; its last stage feeds the response queue.
    logic [LATENCY-1:0] dl_v_q;
    resp_t              dl_q [LATENCY];

    // Response queue, entry 0 is the head.
    resp_t           fifo_q [LATENCY];
    resp_t           fifo_d [LATENCY];
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d, cnt_tmp;
    logic [CW-1:0]   out_q, out_d;

    logic [BITS-1:0] off, word;
    logic [IW-1:0]   idx;
    logic            hit, accept, resp_hs, last_v, push, pop, rv;
    resp_t           last, head, cap;

    // Address below base wraps to a huge offset and misses naturally.
    assign off  = bus.req_addr - base_q;
    assign word = off / BYTES_W;
    assign hit  = ((off % BYTES_W) == '0) && (word < DEPTH_W);
    assign idx  = IW'(word);

    assign last_v = dl_v_q[LATENCY-1];
    assign last   = dl_q[LATENCY-1];

    // An empty queue lets the delay-line output go straight to the port, so
    // the queue adds no latency when the consumer keeps up.
    assign rv   = (fifo_cnt_q != '0) || last_v;
    assign head = (fifo_cnt_q != '0) ? fifo_q[0] : last;

    // All outputs are forced quiet while reset (rst_n=1) is held.
    assign bus.resp_valid = !rst_n && rv;
    assign bus.resp_rdata = bus.resp_valid ? head.rdata : '0;
    assign bus.resp_err   = bus.resp_valid ? head.err : 1'b0;
    assign resp_hs        = bus.resp_valid && bus.resp_ready;
    assign bus.req_ready  = !rst_n && ((out_q < LAT_W) || resp_hs);
    assign accept         = bus.req_valid && bus.req_ready;

    // Read data is the pre-write word value; writes and misses return 0.
    always_comb begin
        cap.err   = !hit;
        cap.rdata = (hit && !bus.req_wen) ? mem_q[idx] : '0;
    end

    always_comb begin
        fifo_d  = fifo_q;
        cnt_tmp = fifo_cnt_q;
        pop     = resp_hs && (fifo_cnt_q != '0);
        push    = last_v && !(resp_hs && (fifo_cnt_q == '0));
        if (pop) begin
            for (int i = 0; i < LATENCY - 1; i++) fifo_d[i] = fifo_q[i+1];
            cnt_tmp = cnt_tmp - CW'(1);
        end
        if (push) begin
            for (int i = 0; i < LATENCY; i++)
                if (CW'(i) == cnt_tmp) fifo_d[i] = last;
        end
        fifo_cnt_d = push ? cnt_tmp + CW'(1) : cnt_tmp;
        out_d      = out_q + CW'(accept) - CW'(resp_hs);
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            base_q     <= BITS'(offset);
            dl_v_q     <= '0;
            fifo_cnt_q <= '0;
            out_q      <= '0;
            for (int i = 0; i < WORD_DEPTH; i++) mem_q[i] <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dl_q[i]   <= '0;
                fifo_q[i] <= '0;
            end
        end else begin
            dl_v_q[0] <= accept;
            dl_q[0]   <= cap;
            for (int i = 1; i < LATENCY; i++) begin
                dl_v_q[i] <= dl_v_q[i-1];
                dl_q[i]   <= dl_q[i-1];
            end
            fifo_q     <= fifo_d;
            fifo_cnt_q <= fifo_cnt_d;
            out_q      <= out_d;
            if (accept && hit && bus.req_wen) begin
                for (int k = 0; k < BYTES; k++)
                    if (bus.req_wmask[k]) mem_q[idx][8*k +: 8] <= bus.req_wdata[8*k +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mapped_mem_ctrl.sv
// tb_mapped_mem_ctrl
//   Directed bench: three instances (LATENCY 1, 2, 3) sharing clock, reset
//   and offset. Inputs are driven on the falling edge, outputs sampled
//   1 time unit later, well before the next rising edge.
module tb_mapped_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] offset;
    int          total = 0;
    int          bad   = 0;
    int          nxt, rcv;
    logic [31:0] av [5];
    logic [31:0] bv [8];

    always #5 clk = ~clk;

    mapped_mem_ctrl_if #(.BITS(32)) b1 ();
    mapped_mem_ctrl_if #(.BITS(32)) b2 ();
    mapped_mem_ctrl_if #(.BITS(32)) b3 ();

    mapped_mem_ctrl #(.BITS(32), .WORD_DEPTH(32), .LATENCY(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .offset(offset), .bus(b1));
    mapped_mem_ctrl #(.BITS(32), .WORD_DEPTH(32), .LATENCY(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .offset(offset), .bus(b2));
    mapped_mem_ctrl #(.BITS(32), .WORD_DEPTH(32), .LATENCY(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .offset(offset), .bus(b3));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer1(input string tag, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask,
                         input logic [31:0] exp_rd, input logic exp_err);
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_wen = wen; b1.req_addr = addr;
        b1.req_wdata = wdata; b1.req_wmask = mask; b1.resp_ready = 1'b1;
        #1 chk({tag, "_rdy"}, b1.req_ready, 1);
        @(negedge clk);
        b1.req_valid = 1'b0;
        #1;
        chk({tag, "_vld"}, b1.resp_valid, 1);
        chk({tag, "_rd"}, b1.resp_rdata, exp_rd);
        chk({tag, "_err"}, b1.resp_err, exp_err);
    endtask

    task automatic xfer3(input string tag, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd,
                         input logic exp_err);
        int n;
        @(negedge clk);
        b3.req_valid = 1'b1; b3.req_wen = wen; b3.req_addr = addr;
        b3.req_wdata = wdata; b3.req_wmask = 4'hF; b3.resp_ready = 1'b1;
        #1 n = 0;
        while (!b3.req_ready && n < 10) begin @(negedge clk); #1 n++; end
        chk({tag, "_rdy"}, b3.req_ready, 1);
        @(negedge clk);
        b3.req_valid = 1'b0;
        #1 n = 0;
        while (!b3.resp_valid && n < 10) begin @(negedge clk); #1 n++; end
        chk({tag, "_vld"}, b3.resp_valid, 1);
        chk({tag, "_rd"}, b3.resp_rdata, exp_rd);
        chk({tag, "_err"}, b3.resp_err, exp_err);
    endtask

    initial begin
        for (int i = 0; i < 5; i++) av[i] = 32'h1111_1111 * (i + 1);
        for (int i = 0; i < 8; i++) bv[i] = 32'hB000_0000 + i;
        b1.req_valid = 0; b1.req_wen = 0; b1.req_addr = 0; b1.req_wdata = 0; b1.req_wmask = 0; b1.resp_ready = 1;
        b2.req_valid = 0; b2.req_wen = 0; b2.req_addr = 0; b2.req_wdata = 0; b2.req_wmask = 0; b2.resp_ready = 1;
        b3.req_valid = 0; b3.req_wen = 0; b3.req_addr = 0; b3.req_wdata = 0; b3.req_wmask = 0; b3.resp_ready = 1;
        rst_n  = 1'b1;
        offset = 32'h1000;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rdy", b1.req_ready, 0);
        chk("rst_vld", b1.resp_valid, 0);
        chk("rst_rd", b1.resp_rdata, 0);
        rst_n = 1'b0;
        #1 chk("post_rst_rdy", b1.req_ready, 1);

        // LATENCY=1: basic write/read, masked write, misses
        xfer1("w_full", 1, 32'h1008, 32'hDEADBEEF, 4'hF, 32'h0, 0);
        xfer1("r_full", 0, 32'h1008, 32'h0, 4'h0, 32'hDEADBEEF, 0);
        xfer1("w_mask", 1, 32'h1008, 32'h11223344, 4'b0101, 32'h0, 0);
        xfer1("r_mask", 0, 32'h1008, 32'h0, 4'h0, 32'hDE22BE44, 0);
        xfer1("r_below", 0, 32'h0FFC, 32'h0, 4'h0, 32'h0, 1);
        xfer1("r_above", 0, 32'h1080, 32'h0, 4'h0, 32'h0, 1);
        xfer1("r_misal", 0, 32'h1002, 32'h0, 4'h0, 32'h0, 1);
        xfer1("w_misal", 1, 32'h100A, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
        xfer1("w_below", 1, 32'h0FFC, 32'hFFFFFFFF, 4'hF, 32'h0, 1);
        xfer1("r_keep", 0, 32'h1008, 32'h0, 4'h0, 32'hDE22BE44, 0);
        xfer1("r_last", 0, 32'h107C, 32'h0, 4'h0, 32'h0, 0);

        // Read-after-write on consecutive cycles
        @(negedge clk);
        b1.req_valid = 1; b1.req_wen = 1; b1.req_addr = 32'h1010;
        b1.req_wdata = 32'hCAFEF00D; b1.req_wmask = 4'hF;
        @(negedge clk);
        b1.req_wen = 0;
        #1;
        chk("raw_w_vld", b1.resp_valid, 1);
        chk("raw_rdy", b1.req_ready, 1);
        @(negedge clk);
        b1.req_valid = 0;
        #1;
        chk("raw_r_vld", b1.resp_valid, 1);
        chk("raw_r_rd", b1.resp_rdata, 32'hCAFEF00D);
        xfer1("w_zmask", 1, 32'h1010, 32'hFFFFFFFF, 4'h0, 32'h0, 0);
        xfer1("r_zmask", 0, 32'h1010, 32'h0, 4'h0, 32'hCAFEF00D, 0);

        // LATENCY=3: preload, then backpressure with 5 reads
        for (int i = 0; i < 5; i++) xfer3($sformatf("l3_pre%0d", i), 1, 32'h1000 + 4 * i, av[i], 32'h0, 0);
        repeat (4) @(negedge clk);
        nxt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            b3.resp_ready = 0; b3.req_valid = 1; b3.req_wen = 0;
            b3.req_addr = 32'h1000 + 4 * nxt;
            #1;
            if (c == 3) begin
                chk("l3_full_rdy", b3.req_ready, 0);
                chk("l3_head", b3.resp_rdata, av[0]);
            end
            if (c == 4) begin
                chk("l3_hold_vld", b3.resp_valid, 1);
                chk("l3_hold_rd", b3.resp_rdata, av[0]);
            end
            if (b3.req_ready) nxt++;
        end
        chk("l3_acc3", nxt, 3);
        rcv = 0;
        for (int c = 0; c < 20 && rcv < 5; c++) begin
            @(negedge clk);
            b3.resp_ready = 1;
            b3.req_valid  = (nxt < 5);
            b3.req_addr   = 32'h1000 + 4 * nxt;
            #1;
            if (b3.resp_valid) begin
                chk($sformatf("l3_drain%0d", rcv), b3.resp_rdata, av[rcv]);
                rcv++;
            end
            if (b3.req_valid && b3.req_ready) nxt++;
        end
        b3.req_valid = 0;
        chk("l3_all_resp", rcv, 5);
        chk("l3_all_acc", nxt, 5);

        // LATENCY=2: preload 8 words, then 8 back-to-back reads
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            b2.req_valid = 1; b2.req_wen = 1; b2.req_addr = 32'h1000 + 4 * i;
            b2.req_wdata = bv[i]; b2.req_wmask = 4'hF; b2.resp_ready = 1;
        end
        @(negedge clk);
        b2.req_valid = 0;
        repeat (4) @(negedge clk);
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            b2.req_valid = (j < 8); b2.req_wen = 0; b2.req_addr = 32'h1000 + 4 * j;
            #1;
            if (j < 8) chk($sformatf("l2_rdy%0d", j), b2.req_ready, 1);
            if (j >= 2) begin
                chk($sformatf("l2_vld%0d", j), b2.resp_valid, 1);
                chk($sformatf("l2_rd%0d", j), b2.resp_rdata, bv[j-2]);
            end else begin
                chk($sformatf("l2_idle%0d", j), b2.resp_valid, 0);
            end
        end
        b2.req_valid = 0;

        // Reset with responses pending on LATENCY=3, new offset
        @(negedge clk);
        b3.resp_ready = 0; b3.req_valid = 1; b3.req_wen = 0; b3.req_addr = 32'h1000;
        @(negedge clk);
        b3.req_addr = 32'h1004;
        @(negedge clk);
        b3.req_valid = 0;
        @(negedge clk);
        rst_n  = 1'b1;
        offset = 32'h2000;
        #1;
        chk("mid_rst_rdy", b3.req_ready, 0);
        chk("mid_rst_vld", b3.resp_valid, 0);
        @(negedge clk);
        rst_n = 1'b0;
        b3.resp_ready = 1;
        #1;
        chk("after_rst_vld", b3.resp_valid, 0);
        chk("after_rst_rdy", b3.req_ready, 1);
        xfer3("nr_w0", 0, 32'h2000, 32'h0, 32'h0, 0);
        xfer3("nr_w4", 0, 32'h2010, 32'h0, 32'h0, 0);
        xfer3("nr_old", 0, 32'h1000, 32'h0, 32'h0, 1);
        xfer3("nr_wr", 1, 32'h2004, 32'h5A5A5A5A, 32'h0, 0);
        xfer3("nr_rd", 0, 32'h2004, 32'h0, 32'h5A5A5A5A, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
